// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side signals of the Chip-8 memory arbiter.
// slave = arbiter side, master = requesters + RAM side.
interface mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 8
);
    logic          uploading;
    logic          up_req;
    logic [AW-1:0] up_addr;
    logic [DW-1:0] up_data;
    logic          up_ack;
    logic          bl_req;
    logic          bl_we;
    logic [AW-1:0] bl_addr;
    logic [DW-1:0] bl_wdata;
    logic          bl_ack;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [1:0]    gnt;

    modport slave (
        input  uploading, up_req, up_addr, up_data,
        input  bl_req, bl_we, bl_addr, bl_wdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output up_ack, bl_ack, cpu_ack, rd_data,
        output mem_addr, mem_we, mem_wdata, busy, gnt
    );

    modport master (
        output uploading, up_req, up_addr, up_data,
        output bl_req, bl_we, bl_addr, bl_wdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  up_ack, bl_ack, cpu_ack, rd_data,
        input  mem_addr, mem_we, mem_wdata, busy, gnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port Chip-8 RAM arbiter: uploader / blitter / CPU, one access per 3 cycles.
// Optional MEM_ARB_RR_EN: round-robin between blitter and CPU (default fixed priority).
module mem_arbiter #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          res,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {G_NONE = 2'd0, G_UP = 2'd1, G_BL = 2'd2, G_CPU = 2'd3} gnt_t;

    state_t        state;
    gnt_t          gnt_q;
    gnt_t          sel;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_we_q;
    logic          busy_q;
    logic          up_ack_q;
    logic          bl_ack_q;
    logic          cpu_ack_q;
`ifdef MEM_ARB_RR_EN
    logic          rr_cpu;  // 1: CPU wins the next blitter/CPU tie
`endif

    // Uploader always outranks; during an upload it is the only eligible requester.
    always_comb begin
        sel = G_NONE;
        if (bus.up_req) begin
            sel = G_UP;
        end else if (!bus.uploading) begin
`ifdef MEM_ARB_RR_EN
            if (bus.bl_req && (!bus.cpu_req || !rr_cpu))
                sel = G_BL;
            else if (bus.cpu_req)
                sel = G_CPU;
`else
            if (bus.bl_req)
                sel = G_BL;
            else if (bus.cpu_req)
                sel = G_CPU;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= IDLE;
            gnt_q       <= G_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            up_ack_q    <= 1'b0;
            bl_ack_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_cpu      <= 1'b0;
`endif
        end else begin
            up_ack_q  <= 1'b0;
            bl_ack_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    gnt_q    <= sel;
                    mem_we_q <= 1'b0;
                    case (sel)
                        G_UP: begin
                            mem_addr_q  <= bus.up_addr;
                            mem_wdata_q <= bus.up_data;
                            mem_we_q    <= 1'b1;
                        end
                        G_BL: begin
                            mem_addr_q  <= bus.bl_addr;
                            mem_wdata_q <= bus.bl_wdata;
                            mem_we_q    <= bus.bl_we;
                        end
                        G_CPU: begin
                            mem_addr_q  <= bus.cpu_addr;
                            mem_wdata_q <= bus.cpu_wdata;
                            mem_we_q    <= bus.cpu_we;
                        end
                        default: ;
                    endcase
                    if (sel != G_NONE) begin
                        state  <= ISSUE;
                        busy_q <= 1'b1;
                    end
`ifdef MEM_ARB_RR_EN
                    if (sel == G_BL)
                        rr_cpu <= 1'b1;
                    else if (sel == G_CPU)
                        rr_cpu <= 1'b0;
`endif
                end
                ISSUE: begin
                    // RAM samples mem_* at the end of this cycle; read data lands in DONE.
                    up_ack_q  <= (gnt_q == G_UP);
                    bl_ack_q  <= (gnt_q == G_BL);
                    cpu_ack_q <= (gnt_q == G_CPU);
                    mem_we_q  <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    gnt_q  <= G_NONE;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.busy      = busy_q;
    assign bus.gnt       = gnt_q;
    assign bus.up_ack    = up_ack_q;
    assign bus.bl_ack    = bl_ack_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.rd_data   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-requester expectation queues, RAM model, ack monitor.
module tb_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic res = 1'b1;
    logic ram_init = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .res(res), .bus(bus));

    logic [DW-1:0] ram     [4096];
    logic [DW-1:0] init_val[4096];
    logic [DW-1:0] ref_mem [4096];

    exp_t q_up[$];
    exp_t q_bl[$];
    exp_t q_cpu[$];
    int   log_who[$];
    int   log_cyc[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int total_acks = 0;
    logic [1:0] prev_gnt = 2'd0;

    // Synchronous RAM with one-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_val[i];
        end else begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    function automatic void push_exp(input int who, input logic we,
                                     input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.we = we;
        e.a  = a;
        e.d  = we ? d : ref_mem[a];
        if (we) ref_mem[a] = d;
        case (who)
            1: q_up.push_back(e);
            2: q_bl.push_back(e);
            default: q_cpu.push_back(e);
        endcase
    endfunction

    // Monitor: every ack pops its requester's queue and is compared to the model
    always @(negedge clk) begin
        int nack;
        int who;
        exp_t e;
        logic have;
        if (!res) begin
            nack = int'(bus.up_ack) + int'(bus.bl_ack) + int'(bus.cpu_ack);
            if (nack != 0) begin
                total_acks++;
                chk("ack_onehot", nack, 1);
                who = bus.up_ack ? 1 : (bus.bl_ack ? 2 : 3);
                have = 1'b0;
                case (who)
                    1: if (q_up.size() != 0)  begin e = q_up.pop_front();  have = 1'b1; end
                    2: if (q_bl.size() != 0)  begin e = q_bl.pop_front();  have = 1'b1; end
                    default: if (q_cpu.size() != 0) begin e = q_cpu.pop_front(); have = 1'b1; end
                endcase
                if (!have) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: requester %0d acked with nothing outstanding", who);
                end else if (e.we) begin
                    chk("wr_data", int'(ram[e.a]), int'(e.d));
                end else begin
                    chk("rd_data", int'(bus.rd_data), int'(e.d));
                end
                chk("gnt_in_issue", int'(prev_gnt), who);
                log_who.push_back(who);
                log_cyc.push_back(cyc);
            end
        end
        prev_gnt <= bus.gnt;
    end

    function automatic logic ack_of(input int who);
        case (who)
            1: return bus.up_ack;
            2: return bus.bl_ack;
            default: return bus.cpu_ack;
        endcase
    endfunction

    task automatic set_req(input int who, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        case (who)
            1: begin bus.up_req = v; bus.up_addr = a; bus.up_data = d; end
            2: begin bus.bl_req = v; bus.bl_we = we; bus.bl_addr = a; bus.bl_wdata = d; end
            default: begin bus.cpu_req = v; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; end
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
    task automatic xact(input int who, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int budget, input bit do_push,
                        output int lat);
        if (do_push) push_exp(who, we, a, d);
        set_req(who, 1'b1, we, a, d);
        lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (ack_of(who)) begin lat = c; break; end
        end
        if (lat == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: requester %0d got no ack within %0d cycles", who, budget);
        end
        @(posedge clk); #1;
        set_req(who, 1'b0, we, a, d);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 res = 1'b1;
        @(posedge clk); #1 res = 1'b0;
    endtask

    task automatic rand_driver(input int who, input int n, input logic [AW-1:0] base);
        int lat;
        logic we;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            we = (who == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            xact(who, we, base + AW'($urandom_range(0, 7)), DW'($urandom), 80, 1'b1, lat);
        end
    endtask

    initial begin
        int lat_a, lat_b, base;
        int seq[4];
        int ptr;
        bus.uploading = 1'b0;
        set_req(1, 1'b0, 1'b0, '0, '0);
        set_req(2, 1'b0, 1'b0, '0, '0);
        set_req(3, 1'b0, 1'b0, '0, '0);
        bus.mem_rdata = '0;
        for (int i = 0; i < 4096; i++) begin
            init_val[i] = DW'($urandom);
            ref_mem[i]  = init_val[i];
        end

        // Reset values
        ram_init = 1'b1;
        repeat (3) @(posedge clk);
        #1 ram_init = 1'b0;
        @(negedge clk);
        chk("rst_mem_we", int'(bus.mem_we), 0);
        chk("rst_mem_addr", int'(bus.mem_addr), 0);
        chk("rst_mem_wdata", int'(bus.mem_wdata), 0);
        chk("rst_acks", int'({bus.up_ack, bus.bl_ack, bus.cpu_ack}), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_gnt", int'(bus.gnt), 0);
        @(posedge clk); #1 res = 1'b0;

        // Upload locks out a pending CPU read of the same address
        bus.uploading = 1'b1;
        @(posedge clk); #1;
        push_exp(1, 1'b1, 12'h200, 8'hA5);
        push_exp(3, 1'b0, 12'h200, 8'h00);
        fork
            xact(1, 1'b1, 12'h200, 8'hA5, 20, 1'b0, lat_a);
            xact(3, 1'b0, 12'h200, 8'h00, 60, 1'b0, lat_b);
            begin repeat (15) @(posedge clk); #1 bus.uploading = 1'b0; end
        join
        chk("up_latency", lat_a, 3);
        chk("cpu_after_upload_latency", lat_b, 18);

        // Back-to-back CPU reads with request held
        for (int i = 0; i < 4; i++) push_exp(3, 1'b0, AW'(i), 8'h00);
        base = log_cyc.size();
        set_req(3, 1'b1, 1'b0, 12'h000, 8'h00);
        for (int i = 0; i < 4; i++) begin
            lat_a = 0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (bus.cpu_ack) begin lat_a = c; break; end
            end
            chk("b2b_ack_seen", lat_a, 3);
            @(posedge clk); #1;
            bus.cpu_addr = AW'(i + 1);
        end
        bus.cpu_req = 1'b0;
        chk("b2b_count", log_cyc.size() - base, 4);
        for (int i = 1; i < 4 && base + i < log_cyc.size(); i++)
            chk("b2b_spacing", log_cyc[base + i] - log_cyc[base + i - 1], 3);

        // Blitter and CPU requesting together: predicted grant order from the policy
        do_reset();
        ptr = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            seq[k] = (ptr == 0) ? 2 : 3;
            ptr = 1 - ptr;
`else
            seq[k] = 2;
`endif
            push_exp(seq[k], 1'b0, (seq[k] == 2) ? 12'h900 : 12'h100, 8'h00);
        end
        base = log_who.size();
        set_req(2, 1'b1, 1'b0, 12'h900, 8'h00);
        set_req(3, 1'b1, 1'b0, 12'h100, 8'h00);
        repeat (12) @(posedge clk);
        #1;
        bus.bl_req  = 1'b0;
        bus.cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("contend_count", log_who.size() - base, 4);
        for (int k = 0; k < 4 && base + k < log_who.size(); k++)
            chk("contend_order", log_who[base + k], seq[k]);
        // With fixed priority the starved CPU leaves nothing behind here
        chk("contend_q_empty", q_bl.size() + q_cpu.size(), 0);

        // Blitter write then CPU read-back
        xact(2, 1'b1, 12'hF00, 8'h3C, 10, 1'b1, lat_a);
        chk("bl_wr_latency", lat_a, 3);
        xact(3, 1'b0, 12'hF00, 8'h00, 10, 1'b1, lat_a);
        chk("cpu_rd_latency", lat_a, 3);

        // Reset during ISSUE of a CPU read: ack suppressed
        base = total_acks;
        set_req(3, 1'b1, 1'b0, 12'h010, 8'h00);
        @(posedge clk); #1;
        chk("issue_busy", int'(bus.busy), 1);
        chk("issue_gnt", int'(bus.gnt), 3);
        res = 1'b1;
        @(posedge clk); #1;
        res = 1'b0;
        bus.cpu_req = 1'b0;
        chk("post_rst_mem_we", int'(bus.mem_we), 0);
        chk("post_rst_gnt", int'(bus.gnt), 0);
        chk("post_rst_busy", int'(bus.busy), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("rst_ack_suppressed", total_acks - base, 0);

        // Reset during ISSUE of a CPU write: the write still lands
        set_req(3, 1'b1, 1'b1, 12'h020, 8'h77);
        @(posedge clk); #1;
        res = 1'b1;
        @(posedge clk); #1;
        res = 1'b0;
        bus.cpu_req = 1'b0;
        ref_mem[12'h020] = 8'h77;
        @(negedge clk);
        chk("rst_write_in_flight", int'(ram[12'h020]), 8'h77);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_ack_suppressed", total_acks - base, 0);

        // Upload starts during DONE of a blitter read
        push_exp(2, 1'b0, 12'h901, 8'h00);
        fork
            xact(2, 1'b0, 12'h901, 8'h00, 10, 1'b0, lat_a);
            begin @(posedge clk); @(posedge clk); #1 bus.uploading = 1'b1; end
        join
        chk("bl_done_completes", lat_a, 3);
        push_exp(2, 1'b0, 12'h902, 8'h00);
        fork
            xact(2, 1'b0, 12'h902, 8'h00, 40, 1'b0, lat_b);
            begin repeat (10) @(posedge clk); #1 bus.uploading = 1'b0; end
        join
        chk("bl_locked_latency", lat_b, 13);

        // Randomised mix; each requester owns its own address window
        fork
            rand_driver(1, 20, 12'hC00);
            rand_driver(2, 25, 12'hA00);
            rand_driver(3, 25, 12'h300);
        join
        repeat (4) @(posedge clk);
        chk("final_q_empty", q_up.size() + q_bl.size() + q_cpu.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
